// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-port bundle between the interconnect and ahb_sram_slave.
interface ahb_sram_slave_if #(
    parameter int unsigned HADDR_WIDTH = 32,
    parameter int unsigned HDATA_WIDTH = 32
);
    logic                   HSEL_i;
    logic [1:0]             HTRANS_i;
    logic [2:0]             HBURST_i;
    logic [2:0]             HSIZE_i;
    logic                   HWRITE_i;
    logic [HADDR_WIDTH-1:0] HADDR_i;
    logic [HDATA_WIDTH-1:0] HWDATA_i;
    logic                   HREADY_i;
    logic [HDATA_WIDTH-1:0] HRDATA_o;
    logic                   HREADYOUT_o;
    logic                   HRESP_o;
    logic                   HEXOKAY_o;

    modport slave (
        input  HSEL_i, HTRANS_i, HBURST_i, HSIZE_i, HWRITE_i, HADDR_i, HWDATA_i, HREADY_i,
        output HRDATA_o, HREADYOUT_o, HRESP_o, HEXOKAY_o
    );

    modport master (
        output HSEL_i, HTRANS_i, HBURST_i, HSIZE_i, HWRITE_i, HADDR_i, HWDATA_i, HREADY_i,
        input  HRDATA_o, HREADYOUT_o, HRESP_o, HEXOKAY_o
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM responder with burst-aware wait states and byte-lane writes.
// Define AHB_SRAM_SLAVE_ERR_EN to return a two-cycle ERROR for illegal accesses.
module ahb_sram_slave #(
    parameter int unsigned HADDR_WIDTH = 32,
    parameter int unsigned HDATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned REGION_BITS = 28,
    parameter int unsigned WAIT_NONSEQ = 1,
    parameter int unsigned WAIT_SEQ    = 0
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    ahb_sram_slave_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic [IDX_W-1:0]       idx_q;
    logic [3:0]             lanes_q;
    logic                   wr_q;
    logic [31:0]            mem [MEM_DEPTH];

    logic [HADDR_WIDTH-1:0] haddr;
    logic [HDATA_WIDTH-1:0] hwdata;
    logic                   can_accept;
    logic                   accept;
    logic                   illegal;
    logic                   commit;
    logic [IDX_W-1:0]       acc_idx;
    logic [3:0]             acc_lanes;
    logic [3:0]             acc_wait;
    logic [31:0]            rd_next;
    logic                   unused_ok;

    assign haddr      = bus.HADDR_i;
    assign hwdata     = bus.HWDATA_i;
    assign can_accept = (state == S_IDLE) || (state == S_LAST) || (state == S_ERR2);
    assign accept     = can_accept && bus.HSEL_i && bus.HREADY_i && bus.HTRANS_i[1];
    assign acc_idx    = haddr[IDX_W+1:2];
    assign acc_wait   = bus.HTRANS_i[0] ? 4'(WAIT_SEQ) : 4'(WAIT_NONSEQ);
    assign commit     = (state == S_LAST) && wr_q;
    assign bus.HEXOKAY_o = 1'b0;
    assign unused_ok  = &{1'b0, bus.HBURST_i, haddr, hwdata};

`ifdef AHB_SRAM_SLAVE_ERR_EN
    localparam int unsigned MEM_BYTES = MEM_DEPTH * 4;
    assign illegal = (32'(haddr[REGION_BITS-1:0]) >= MEM_BYTES)
                  || ((bus.HSIZE_i == 3'd1) && haddr[0])
                  || ((bus.HSIZE_i == 3'd2) && (haddr[1:0] != 2'b00))
                  || (bus.HSIZE_i > 3'd2);
`else
    localparam int unsigned unused_region = REGION_BITS;
    assign illegal = 1'b0;
`endif

    // Little-endian lane enables; oversize transfers fall back to a full word.
    always_comb begin : lane_decode
        acc_lanes = 4'b1111;
        case (bus.HSIZE_i)
            3'd0:    acc_lanes = 4'b0001 << haddr[1:0];
            3'd1:    acc_lanes = haddr[1] ? 4'b1100 : 4'b0011;
            default: acc_lanes = 4'b1111;
        endcase
    end

    // Read data for the next transfer, merging a write that commits on the same edge.
    always_comb begin : read_forward
        rd_next = mem[acc_idx];
        if (commit && (idx_q == acc_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes_q[b]) rd_next[b*8 +: 8] = hwdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin : fsm
        if (!HRESETn) begin
            state           <= S_IDLE;
            wait_cnt        <= '0;
            idx_q           <= '0;
            lanes_q         <= '0;
            wr_q            <= 1'b0;
            bus.HREADYOUT_o <= 1'b1;
            bus.HRESP_o     <= 1'b0;
            bus.HRDATA_o    <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state           <= S_LAST;
                        bus.HREADYOUT_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state           <= S_ERR2;
                    bus.HREADYOUT_o <= 1'b1;
                    bus.HRESP_o     <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        idx_q   <= acc_idx;
                        lanes_q <= acc_lanes;
                        wr_q    <= bus.HWRITE_i && !illegal;
                        if (illegal) begin
                            state           <= S_ERR1;
                            bus.HREADYOUT_o <= 1'b0;
                            bus.HRESP_o     <= 1'b1;
                            bus.HRDATA_o    <= '0;
                        end else begin
                            bus.HRESP_o  <= 1'b0;
                            bus.HRDATA_o <= rd_next;
                            if (acc_wait == 4'd0) begin
                                state           <= S_LAST;
                                bus.HREADYOUT_o <= 1'b1;
                            end else begin
                                state           <= S_WAIT;
                                wait_cnt        <= acc_wait - 4'd1;
                                bus.HREADYOUT_o <= 1'b0;
                            end
                        end
                    end else begin
                        state           <= S_IDLE;
                        wr_q            <= 1'b0;
                        bus.HREADYOUT_o <= 1'b1;
                        bus.HRESP_o     <= 1'b0;
                        bus.HRDATA_o    <= '0;
                    end
                end
            endcase
        end
    end

    // Storage is not reset; a write lands only on the edge that ends its LAST cycle.
    always_ff @(posedge HCLK) begin : mem_write
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes_q[b]) mem[idx_q][b*8 +: 8] <= hwdata[b*8 +: 8];
            end
        end
    end
endmodule
